// File: rtl/instr_step_sequencer_if.sv
// Issue-side bus between the instruction source (master) and instr_step_sequencer (slave).
// Handshake: an instruction is accepted at a rising Clock edge where Run && ready; instr_in is sampled only then.
interface instr_step_sequencer_if #(
    parameter int IW = 12
);
    logic          Run;
    logic [IW-1:0] instr_in;
    logic          ready;
    logic [3:0]    func_instruction;
    logic [IW-1:0] instruction_F;
    logic [1:0]    step;
    logic          Done;
    logic          illegal;

    modport master (
        output Run, instr_in,
        input  ready, func_instruction, instruction_F, step, Done, illegal
    );

    modport slave (
        input  Run, instr_in,
        output ready, func_instruction, instruction_F, step, Done, illegal
    );
endinterface

// File: rtl/instr_step_sequencer.sv
// Multi-cycle issue sequencer: latches an instruction, holds its function code for N steps, pulses Done.
// Optional macro SEQ_PENDING_BUF_EN adds a one-entry pending buffer for back-to-back issue.
module instr_step_sequencer #(
    parameter int IW        = 12,
    parameter int ALU_STEPS = 3
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    instr_step_sequencer_if.slave  bus,
    output logic [0:0]             o_dbg_state
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXEC   = 1'b1;
    localparam logic [1:0] ALU_LAST = 2'(ALU_STEPS - 1);

    logic [0:0]    r_state;
    logic [IW-1:0] r_instr;
    logic [3:0]    r_func;
    logic [1:0]    r_step;
    logic [1:0]    r_last;
    logic          r_done;
    logic          r_illegal;
    logic          r_ready;
    logic          r_pend_vld;
    logic [IW-1:0] r_pend_word;

    logic [0:0]    w_state_n;
    logic [IW-1:0] w_instr_n;
    logic [3:0]    w_func_n;
    logic [1:0]    w_step_n;
    logic [1:0]    w_last_n;
    logic          w_done_n;
    logic          w_illegal_n;
    logic          w_ready_n;
    logic          w_pend_vld_n;
    logic [IW-1:0] w_pend_word_n;
    logic          w_load;
    logic          w_accept;
    logic [IW-1:0] w_load_word;
    logic [3:0]    w_load_op;
    logic          w_load_ill;
    logic [1:0]    w_load_last;

    assign w_accept = bus.Run && r_ready;

`ifdef SEQ_PENDING_BUF_EN
    // A buffered word always takes priority over a fresh one when chaining out of Done.
    assign w_load_word = (r_state == S_EXEC && r_done && r_pend_vld) ? r_pend_word : bus.instr_in;
`else
    assign w_load_word = bus.instr_in;
`endif

    assign w_load_op   = w_load_word[IW-1 -: 4];
    assign w_load_ill  = (w_load_op > 4'd4);
    assign w_load_last = (w_load_op == 4'd3 || w_load_op == 4'd4) ? ALU_LAST : 2'd0;

    always_comb begin
        w_state_n     = r_state;
        w_instr_n     = r_instr;
        w_func_n      = r_func;
        w_step_n      = r_step;
        w_last_n      = r_last;
        w_done_n      = 1'b0;
        w_illegal_n   = 1'b0;
        w_pend_vld_n  = r_pend_vld;
        w_pend_word_n = r_pend_word;
        w_load        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) w_load = 1'b1;
            end
            S_EXEC: begin
                if (r_done) begin
                    w_state_n = S_IDLE;
                    w_func_n  = 4'b0000;
                    w_step_n  = 2'd0;
`ifdef SEQ_PENDING_BUF_EN
                    if (r_pend_vld) begin
                        w_load       = 1'b1;
                        w_pend_vld_n = w_accept;
                        if (w_accept) w_pend_word_n = bus.instr_in;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end
`endif
                end else begin
                    w_step_n = r_step + 2'd1;
                    w_done_n = ((r_step + 2'd1) == r_last);
`ifdef SEQ_PENDING_BUF_EN
                    if (w_accept) begin
                        w_pend_vld_n  = 1'b1;
                        w_pend_word_n = bus.instr_in;
                    end
`endif
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_load) begin
            w_state_n   = S_EXEC;
            w_instr_n   = w_load_word;
            w_func_n    = w_load_ill ? 4'b0000 : w_load_op;
            w_step_n    = 2'd0;
            w_last_n    = w_load_last;
            w_done_n    = (w_load_last == 2'd0);
            w_illegal_n = w_load_ill;
        end
    end

`ifdef SEQ_PENDING_BUF_EN
    // Ready also opens in the Done cycle so a new word can slip in while the buffer drains.
    assign w_ready_n = !w_pend_vld_n || (w_state_n == S_EXEC && w_done_n);
`else
    assign w_ready_n = (w_state_n == S_IDLE);
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_func      <= 4'b0000;
            r_step      <= 2'd0;
            r_last      <= 2'd0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_ready     <= 1'b1;
            r_pend_vld  <= 1'b0;
            r_pend_word <= '0;
        end else begin
            r_state     <= w_state_n;
            r_instr     <= w_instr_n;
            r_func      <= w_func_n;
            r_step      <= w_step_n;
            r_last      <= w_last_n;
            r_done      <= w_done_n;
            r_illegal   <= w_illegal_n;
            r_ready     <= w_ready_n;
            r_pend_vld  <= w_pend_vld_n;
            r_pend_word <= w_pend_word_n;
        end
    end

    assign bus.ready            = r_ready;
    assign bus.func_instruction = r_func;
    assign bus.instruction_F    = r_instr;
    assign bus.step             = r_step;
    assign bus.Done             = r_done;
    assign bus.illegal          = r_illegal;
    assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_instr_step_sequencer.sv
// Directed bench for instr_step_sequencer (ALU_STEPS=3); the pending-buffer scenario is built with SEQ_PENDING_BUF_EN.
module tb_instr_step_sequencer;
  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;
  int         n_tests;
  int         n_fail;

  instr_step_sequencer_if #(.IW(12)) bus ();

  instr_step_sequencer #(.IW(12), .ALU_STEPS(3)) dut (
    .Clock       (clk),
    .Resetn      (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] word);
    bus.Run      = 1'b1;
    bus.instr_in = word;
    tick();
    bus.Run      = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n        = 1'b0;
    bus.Run      = 1'b1;
    bus.instr_in = 12'h05A;

    // 1. reset held with Run asserted
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_func", 32'(bus.func_instruction), 32'h0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_instr", 32'(bus.instruction_F), 32'h000);
    check("rst_step", 32'(bus.step), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 2. mv: accepted on the first edge after release
    rst_n = 1'b1;
    tick();
    bus.Run = 1'b0;
    check("mv_func", 32'(bus.func_instruction), 32'h0);
    check("mv_instr", 32'(bus.instruction_F), 32'h05A);
    check("mv_done", 32'(bus.Done), 32'd1);
    check("mv_step", 32'(bus.step), 32'd0);
    check("mv_illegal", 32'(bus.illegal), 32'd0);
    tick();
    check("mv_idle_ready", 32'(bus.ready), 32'd1);
    check("mv_idle_done", 32'(bus.Done), 32'd0);
    check("mv_idle_state", 32'(dbg_state), 32'd0);

    // 3. add: three steps, Done only on step 2
    issue(12'h312);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("add_func%0d", i), 32'(bus.func_instruction), 32'h3);
      check($sformatf("add_step%0d", i), 32'(bus.step), 32'(i));
      check($sformatf("add_done%0d", i), 32'(bus.Done), (i == 2) ? 32'd1 : 32'd0);
`ifndef SEQ_PENDING_BUF_EN
      check($sformatf("add_ready%0d", i), 32'(bus.ready), 32'd0);
`endif
      tick();
    end
    check("add_after_func", 32'(bus.func_instruction), 32'h0);
    check("add_after_ready", 32'(bus.ready), 32'd1);
    check("add_after_done", 32'(bus.Done), 32'd0);

    // 4. opcode 0010 is a single step
    issue(12'h2AB);
    check("op2_func", 32'(bus.func_instruction), 32'h2);
    check("op2_done", 32'(bus.Done), 32'd1);
    check("op2_instr", 32'(bus.instruction_F), 32'h2AB);
    tick();

`ifndef SEQ_PENDING_BUF_EN
    // 5. busy reject: Run during xor is ignored
    issue(12'h421);
    bus.Run      = 1'b1;
    bus.instr_in = 12'h130;
    tick();
    bus.Run = 1'b0;
    check("xor_step1", 32'(bus.step), 32'd1);
    check("xor_func1", 32'(bus.func_instruction), 32'h4);
    tick();
    check("xor_done", 32'(bus.Done), 32'd1);
    check("xor_instr_done", 32'(bus.instruction_F), 32'h421);
    tick();
    check("xor_after_func", 32'(bus.func_instruction), 32'h0);
    check("xor_after_instr", 32'(bus.instruction_F), 32'h421);
    check("xor_after_state", 32'(dbg_state), 32'd0);
`else
    // 5. pending buffer: mvi queued during add runs with no idle gap
    issue(12'h312);
    check("pend_ready_step0", 32'(bus.ready), 32'd1);
    issue(12'h130);
    check("pend_ready_full", 32'(bus.ready), 32'd0);
    check("pend_step1", 32'(bus.step), 32'd1);
    tick();
    check("pend_add_done", 32'(bus.Done), 32'd1);
    check("pend_add_func", 32'(bus.func_instruction), 32'h3);
    tick();
    check("pend_mvi_func", 32'(bus.func_instruction), 32'h1);
    check("pend_mvi_instr", 32'(bus.instruction_F), 32'h130);
    check("pend_mvi_done", 32'(bus.Done), 32'd1);
    check("pend_mvi_step", 32'(bus.step), 32'd0);
    tick();
    check("pend_idle_state", 32'(dbg_state), 32'd0);
`endif

    // 6. illegal opcode
    issue(12'h9FF);
    check("ill_func", 32'(bus.func_instruction), 32'h0);
    check("ill_done", 32'(bus.Done), 32'd1);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    check("ill_instr", 32'(bus.instruction_F), 32'h9FF);
    tick();
    check("ill_after_flag", 32'(bus.illegal), 32'd0);
    check("ill_after_done", 32'(bus.Done), 32'd0);

    // 7. async reset mid-add at step 1
    issue(12'h312);
    tick();
    check("abort_pre_step", 32'(bus.step), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_func", 32'(bus.func_instruction), 32'h0);
    check("abort_step", 32'(bus.step), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_instr", 32'(bus.instruction_F), 32'h000);
    tick();
    check("abort_hold_done", 32'(bus.Done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_post_state", 32'(dbg_state), 32'd0);
    check("abort_post_done", 32'(bus.Done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
